// File: rtl/alu_seq.sv
// Command/response sequencer wrapped around an external N-bit combinational ALU, with an accumulator.
// Optional result flags (rsp_zero, rsp_neg) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_use_acc,
  input  logic         cmd_wb,
  input  logic         acc_clr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [N-1:0] acc,
`ifdef ALU_SEQ_FLAGS_EN
  output logic         rsp_zero,
  output logic         rsp_neg,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         wb_q, wb_d;
  logic [N-1:0] rsp_data_q, rsp_data_d;
  logic [N-1:0] acc_q, acc_d;
  logic         cmd_fire;

  assign cmd_fire = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; cmd_ready stays low while reset is held
  always_comb begin
    cmd_ready = (state_q == IDLE) & ~rst;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Operand capture on handshake, result capture when leaving EXEC
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    wb_d       = wb_q;
    rsp_data_d = rsp_data_q;
    acc_d      = acc_q;
    if (cmd_fire) begin
      alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
      alu_b_d  = cmd_b;
      alu_op_d = cmd_op;
      wb_d     = cmd_wb;
    end
    if (state_q == EXEC) begin
      rsp_data_d = alu_y;
      if (wb_q) acc_d = alu_y;
    end
    // A clear always beats a same-cycle write-back
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      wb_q       <= 1'b0;
      rsp_data_q <= '0;
      acc_q      <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      wb_q       <= wb_d;
      rsp_data_q <= rsp_data_d;
      acc_q      <= acc_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign acc      = acc_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic rsp_zero_q, rsp_zero_d;
  logic rsp_neg_q, rsp_neg_d;

  always_comb begin
    rsp_zero_d = rsp_zero_q;
    rsp_neg_d  = rsp_neg_q;
    if (state_q == EXEC) begin
      rsp_zero_d = (alu_y == '0);
      rsp_neg_d  = alu_y[N-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      rsp_zero_q <= rsp_zero_d;
      rsp_neg_q  <= rsp_neg_d;
    end
  end

  assign rsp_zero = rsp_zero_q;
  assign rsp_neg  = rsp_neg_q;
`endif

endmodule
